// File: rtl/io_input_conditioner.sv
// rtl/io_input_conditioner.sv - per-channel synchroniser, debounce filter, edge detector and sticky event flags
// Optional level interrupt (irq_mask_i/irq_o) is built only when IOC_IRQ_EN is defined.
module io_input_conditioner #(
  parameter int   CH          = 32,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 1000,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [CH-1:0] raw_i,
  input  logic [CH-1:0] evt_clr_i,
`ifdef IOC_IRQ_EN
  input  logic [CH-1:0] irq_mask_i,
  output logic          irq_o,
`endif
  output logic [CH-1:0] level_o,
  output logic [CH-1:0] rise_o,
  output logic [CH-1:0] fall_o,
  output logic [CH-1:0] evt_o
);

  localparam int            CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
  logic [CH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CH-1:0]                  level_q, level_d;
  logic [CH-1:0]                  rise_q, rise_d;
  logic [CH-1:0]                  fall_q, fall_d;
  logic [CH-1:0]                  evt_q, evt_d;
  logic [CH-1:0]                  sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised input agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CH; i++) begin
      if (sync_last[i] != level_q[i]) begin
        if (cnt_q[i] == DEB_MAX) begin
          level_d[i] = sync_last[i];
          rise_d[i]  = sync_last[i];
          fall_d[i]  = ~sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    evt_d = (evt_q & ~evt_clr_i) | rise_d | fall_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{{CH{RESET_LEVEL}}}};
      cnt_q   <= '0;
      level_q <= {CH{RESET_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
      evt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign evt_o   = evt_q;

`ifdef IOC_IRQ_EN
  // Interrupt follows the sticky flags one cycle later.
  logic irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(evt_q & irq_mask_i);
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// tb/tb_io_input_conditioner.sv - scoreboard bench for io_input_conditioner (CH=4, SYNC_STAGES=2, DEB_CYCLES=4)
module tb_io_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw, clr, mask;
  logic [3:0] level, rise, fall, evt;
  logic       irq;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         drv_done = 1'b0;

  typedef struct {
    int         at;
    string      name;
    logic [3:0] lvl;
    logic [3:0] rs;
    logic [3:0] fl;
    logic [3:0] ev;
    logic       iq;
  } exp_t;

  exp_t sb[$];

  io_input_conditioner #(
    .CH(4), .SYNC_STAGES(2), .DEB_CYCLES(4), .RESET_LEVEL(1'b0)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .raw_i     (raw),
    .evt_clr_i (clr),
`ifdef IOC_IRQ_EN
    .irq_mask_i(mask),
    .irq_o     (irq),
`endif
    .level_o   (level),
    .rise_o    (rise),
    .fall_o    (fall),
    .evt_o     (evt)
  );

`ifndef IOC_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int off, input string name, input logic [3:0] l,
                           input logic [3:0] r, input logic [3:0] f, input logic [3:0] e,
                           input logic iq);
    exp_t x;
    x.at = cyc + off; x.name = name;
    x.lvl = l; x.rs = r; x.fl = f; x.ev = e; x.iq = iq;
    sb.push_back(x);
  endtask

  task automatic chk4(input string name, input string fld, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s @cyc %0d: got %b want %b", name, fld, cyc, got, want);
    end
  endtask

  // Monitor: retires every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      if (x.at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s.late: got cyc %0d want cyc %0d", x.name, cyc, x.at);
      end else begin
        chk4(x.name, "level", level, x.lvl);
        chk4(x.name, "rise",  rise,  x.rs);
        chk4(x.name, "fall",  fall,  x.fl);
        chk4(x.name, "evt",   evt,   x.ev);
`ifdef IOC_IRQ_EN
        chk4(x.name, "irq", {3'b000, irq}, {3'b000, x.iq});
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; raw = 4'hF; clr = 4'h0; mask = 4'h0;
    // Reset held three edges with all inputs high
    go(1); expect_at(0, "rst_e1", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    go(1); expect_at(0, "rst_e2", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    go(1); expect_at(0, "rst_e3", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    expect_at(5, "rel_pre",  4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    expect_at(6, "rel_rise", 4'hF, 4'hF, 4'h0, 4'hF, 1'b0);
    expect_at(7, "rel_hold", 4'hF, 4'h0, 4'h0, 4'hF, 1'b0);
    go(7);

    // All channels fall together, then clear flags on quiet cycles
    raw = 4'h0;
    expect_at(5, "all_pre",  4'hF, 4'h0, 4'h0, 4'hF, 1'b0);
    expect_at(6, "all_fall", 4'h0, 4'h0, 4'hF, 4'hF, 1'b0);
    expect_at(7, "all_hold", 4'h0, 4'h0, 4'h0, 4'hF, 1'b0);
    go(7);
    clr = 4'hF; expect_at(1, "clr_all", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    go(1);
    expect_at(1, "clr_idle", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    go(1); clr = 4'h0;

    // Channel 0 rises and stays
    raw = 4'b0001;
    expect_at(5,  "c0_pre",  4'h0,    4'h0,    4'h0, 4'h0,    1'b0);
    expect_at(6,  "c0_rise", 4'b0001, 4'b0001, 4'h0, 4'b0001, 1'b0);
    expect_at(7,  "c0_next", 4'b0001, 4'h0,    4'h0, 4'b0001, 1'b0);
    expect_at(12, "c0_stay", 4'b0001, 4'h0,    4'h0, 4'b0001, 1'b0);
    go(12);

    // Three-cycle glitch on channel 1 is rejected
    raw = 4'b0011;
    expect_at(3, "gl_a", 4'b0001, 4'h0, 4'h0, 4'b0001, 1'b0);
    expect_at(5, "gl_b", 4'b0001, 4'h0, 4'h0, 4'b0001, 1'b0);
    expect_at(6, "gl_c", 4'b0001, 4'h0, 4'h0, 4'b0001, 1'b0);
    expect_at(9, "gl_d", 4'b0001, 4'h0, 4'h0, 4'b0001, 1'b0);
    go(3); raw = 4'b0001;
    go(7);

    // Clear coincident with the fall update: set wins; later clear works
    raw = 4'b0000;
    expect_at(6, "c0_fall", 4'h0, 4'h0, 4'b0001, 4'b0001, 1'b0);
    expect_at(7, "c0_keep", 4'h0, 4'h0, 4'h0,    4'b0001, 1'b0);
    go(5); clr = 4'b0001;
    go(1); clr = 4'b0000;
    go(1); clr = 4'b0001;
    expect_at(1, "c0_clr", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    go(1); clr = 4'b0000;
    go(1);

    // Reset during debounce on channel 2 restarts the full latency
    mask = 4'b0100;
    raw  = 4'b0100;
    go(3); rst = 1'b1;
    expect_at(1, "mid_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    go(1); rst = 1'b0;
    expect_at(5, "c2_pre",  4'h0,    4'h0,    4'h0, 4'h0,    1'b0);
    expect_at(6, "c2_rise", 4'b0100, 4'b0100, 4'h0, 4'b0100, 1'b0);
    expect_at(7, "c2_irq",  4'b0100, 4'h0,    4'h0, 4'b0100, 1'b1);
    go(7);

    // Clear channel 2 flag; interrupt drops a cycle later, and unmasked ch0 edge keeps it low
    clr = 4'b0100;
    expect_at(1, "c2_clr",  4'b0100, 4'h0, 4'h0, 4'h0, 1'b1);
    expect_at(2, "irq_low", 4'b0100, 4'h0, 4'h0, 4'h0, 1'b0);
    go(1); clr = 4'b0000;
    go(1);
    raw = 4'b0101;
    expect_at(6, "c0_mrise", 4'b0101, 4'b0001, 4'h0, 4'b0001, 1'b0);
    expect_at(7, "c0_mnext", 4'b0101, 4'h0,    4'h0, 4'b0001, 1'b0);
    expect_at(8, "c0_mstay", 4'b0101, 4'h0,    4'h0, 4'b0001, 1'b0);
    go(9);
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (drv_done);
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got cyc %0d want completion", cyc);
    $fatal(1);
  end

endmodule
